// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  // Oversample ticks per bit period and derived positions within a bit.
  localparam int OVERSAMPLE = 16;
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int MID_TICK   = OVERSAMPLE / 2;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;
`endif

  // Clocks per oversample tick, truncated; never below one clock.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO for received data.
// Handshake: a byte leaves the FIFO on every clk edge where rd_valid and
// rd_ready are both high; rd_data shows the head byte whenever rd_valid is
// high and holds it until that byte is taken.
// A push into a full FIFO is only accepted when a pop happens in the same
// cycle; otherwise the byte is dropped and overrun pulses for one clock.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [7:0]                     push_data,
  output logic [7:0]                     rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           overrun,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign do_pop   = rd_valid && rd_ready;
  assign do_push  = push && (!full || do_pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // Storage array; when full with a pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo DEPTH; count separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      overrun <= push && full && !do_pop;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 16x oversampled, LSB first,
// feeding a first-word-fall-through FIFO.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a parity_err
// output; otherwise frames are 8N1.
// Handshake: a byte transfers on every clk edge where rd_valid and rd_ready
// are both high; rd_data is valid in the same cycle rd_valid is high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rxd,
  output logic [7:0]                          rd_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic                                frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                                parity_err,
`endif
  output logic                                overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output rx_state_t                           state_dbg
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  START_MID = OS_W'(MID_TICK - 1);
  localparam logic [OS_W-1:0]  BIT_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [1:0]       SETTLE_DONE = 2'd2;

  rx_state_t        state;
  rx_state_t        state_next;
  logic             rx_meta;
  logic             rx_s;
  logic [1:0]       settle;
  logic             armed;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             tick;
  logic             mid_start;
  logic             mid_bit;
  logic             start_det;
  logic             shift_en;
  logic             push;
  logic             frame_bad;
`ifdef UART_RX_PARITY_EN
  logic             par_check;
  logic             par_bad;
`endif

  assign state_dbg = state;
  assign tick      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign mid_start = tick && (os_cnt == START_MID);
  assign mid_bit   = tick && (os_cnt == BIT_LAST);
  // A start edge counts only once the line has been seen high in IDLE, so a
  // line that is already low (after reset or a framing error) is ignored.
  assign start_det = (state == ST_IDLE) && armed && !rx_s;

  // Two-flop synchroniser and start-edge arming; settle waits out the
  // synchroniser's reset value before trusting a high line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      if (settle != SETTLE_DONE) settle <= settle + 2'd1;
      if (start_det)
        armed <= 1'b0;
      else if ((state == ST_IDLE) && (settle == SETTLE_DONE) && rx_s)
        armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-cycle strobes.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    push       = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_check  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_det) state_next = ST_START;
      end
      ST_START: begin
        // Line high at the start-bit midpoint means it was a glitch.
        if (mid_start) state_next = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_next = ST_PARITY;
`else
          if (bit_cnt == 3'd7) state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (mid_bit) begin
          par_check  = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at the stop midpoint leaves half a bit to catch the next edge.
        if (mid_bit) begin
          state_next = ST_IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
          end else begin
            frame_bad = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit timing counters, data shift register and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Tick divider is held at zero in IDLE so it restarts at the start edge.
      if (state == ST_IDLE || tick) div_cnt <= '0;
      else                          div_cnt <= div_cnt + 1'b1;

      // Oversample counter realigns at the start-bit midpoint; every later
      // sample falls 16 ticks apart.
      if (state == ST_IDLE)                   os_cnt <= '0;
      else if (state == ST_START && mid_start) os_cnt <= '0;
      else if (tick)                          os_cnt <= os_cnt + 1'b1;

      if (state != ST_DATA) bit_cnt <= 3'd0;
      else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (shift_en) shift <= {rx_s, shift[7:1]};

      frame_err <= frame_bad;
`ifdef UART_RX_PARITY_EN
      // Even parity: data bits plus parity bit must hold an even number of ones.
      if (state == ST_IDLE) par_bad <= 1'b0;
      else if (par_check)   par_bad <= ^{shift, rx_s};
      parity_err <= par_check && (^{shift, rx_s});
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .overrun   (overrun),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (default 8N1 build).
// A faster baud keeps the run short: DIV = 50e6/(460800*16) truncates to 6,
// so a bit lasts 96 clocks and the glitch pulse is scaled below half a bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 460_800;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_HZ / (BAUD * 16);
  localparam int BIT_CLKS = 16 * DIV;
  localparam int CW       = $clog2(DEPTH + 1);
  // Stop-bit midpoint is 9.5 bit periods after the start edge.
  localparam int STOP_MID_CLKS = (8 + 16 * 9) * DIV;
  localparam int GLITCH_CLKS   = 5 * DIV;

  logic          clk;
  logic          rst_n;
  logic          rxd;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          frame_err;
  logic          overrun;
  logic [CW-1:0] fifo_count;
  rx_state_t     state_dbg;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int checks;
  int failures;
  int cyc;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_ovr;
  int exp_fe;

  int fe_run, fe_pulses, fe_max;
  int ov_run, ov_pulses, ov_max;
  logic rv_prev;
  int rv_rise_cyc;
  int last_start_cyc;
  int lat;
  logic popped_ok;
  logic [7:0] popped_byte;

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun),
    .fifo_count (fifo_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset / monitors ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and rd_valid rise time, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err) begin
      fe_run++;
      if (fe_run == 1) fe_pulses++;
      if (fe_run > fe_max) fe_max = fe_run;
    end else fe_run = 0;
    if (overrun) begin
      ov_run++;
      if (ov_run == 1) ov_pulses++;
      if (ov_run > ov_max) ov_max = ov_run;
    end else ov_run = 0;
    if (rd_valid && !rv_prev) rv_rise_cyc = cyc;
    rv_prev = rd_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Drives one frame starting at a falling edge; optionally raises rd_ready
  // for exactly one cycle at clock offset pop_at and records the head byte.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int pop_at);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    last_start_cyc = cyc;
    for (int c = 0; c < 10 * BIT_CLKS; c++) begin
      rxd = bits[c / BIT_CLKS];
      if (pop_at >= 0 && c == pop_at) begin
        rd_ready    = 1'b1;
        popped_ok   = rd_valid;
        popped_byte = rd_data;
      end else if (pop_at >= 0 && c == pop_at + 1) begin
        rd_ready = 1'b0;
      end
      @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  // Good frame plus reference model update: a full buffer loses the byte.
  task automatic send_good(input logic [7:0] data);
    if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else exp_ovr++;
    send_frame(data, 1'b1, -1);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reads everything out of the FIFO into got_q (bounded).
  task automatic drain_fifo();
    rd_ready = 1'b1;
    for (int c = 0; c < DEPTH + 8; c++) begin
      if (!rd_valid) break;
      got_q.push_back(rd_data);
      @(negedge clk);
    end
    rd_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (int'(fifo_count) !== 0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg); end
    rst_n = 1'b1;
    idle(8);
  endtask

  task automatic test_single_frame();
    rd_ready = 1'b0;
    send_good(8'hA5);
    idle(BIT_CLKS / 4);
    lat = rv_rise_cyc - last_start_cyc;
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_rd_data: got %h expected a5", rd_data); end
    checks++; if (int'(fifo_count) !== 1) begin failures++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    checks++;
    if (lat < STOP_MID_CLKS || lat > STOP_MID_CLKS + 5) begin
      failures++; $display("FAIL single_latency: got %0d clks expected %0d..%0d", lat, STOP_MID_CLKS, STOP_MID_CLKS + 5);
    end
    drain_fifo();
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'hA5) begin failures++; $display("FAIL single_drain: got %0d bytes expected 1 byte a5", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int fe0;
    logic saw_start;
    fe0 = fe_pulses; saw_start = 1'b0;
    rxd = 1'b0;
    repeat (GLITCH_CLKS) begin
      @(negedge clk);
      if (state_dbg !== ST_IDLE) saw_start = 1'b1;
    end
    idle(2 * BIT_CLKS);
    checks++; if (saw_start !== 1'b1) begin failures++; $display("FAIL glitch_start_seen: got %b expected 1", saw_start); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected IDLE", state_dbg); end
    checks++; if (int'(fifo_count) !== 0) begin failures++; $display("FAIL glitch_count: got %0d expected 0", fifo_count); end
    checks++; if (fe_pulses - fe0 !== 0) begin failures++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", fe_pulses - fe0); end
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = fe_pulses; fe_max = 0;
    send_frame(8'h3C, 1'b0, -1);
    idle(BIT_CLKS);
    checks++; if (fe_pulses - fe0 !== 1) begin failures++; $display("FAIL ferr_pulses: got %0d expected 1", fe_pulses - fe0); end
    checks++; if (fe_max !== 1) begin failures++; $display("FAIL ferr_width: got %0d clks expected 1", fe_max); end
    checks++; if (int'(fifo_count) !== 0) begin failures++; $display("FAIL ferr_count: got %0d expected 0", fifo_count); end
    send_good(8'h55);
    idle(BIT_CLKS / 4);
    checks++; if (int'(fifo_count) !== 1) begin failures++; $display("FAIL ferr_next_count: got %0d expected 1", fifo_count); end
    drain_fifo();
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h55) begin failures++; $display("FAIL ferr_next_byte: got %0d bytes expected 1 byte 55", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    int ov0;
    ov0 = ov_pulses; ov_max = 0; exp_ovr = 0;
    rd_ready = 1'b0;
    for (int i = 0; i <= 16; i++) send_good(8'(i));
    idle(BIT_CLKS / 2);
    checks++; if (int'(fifo_count) !== DEPTH) begin failures++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, DEPTH); end
    checks++; if (ov_pulses - ov0 !== exp_ovr) begin failures++; $display("FAIL ovf_pulses: got %0d expected %0d", ov_pulses - ov0, exp_ovr); end
    checks++; if (ov_max !== 1) begin failures++; $display("FAIL ovf_width: got %0d clks expected 1", ov_max); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL ovf_head: got %h expected 00", rd_data); end
  endtask

  // Continues from a full FIFO holding 0x00..0x0F.
  task automatic test_full_push_pop();
    int ov0;
    logic [7:0] head;
    ov0 = ov_pulses;
    head = exp_q.pop_front();
    exp_q.push_back(8'h77);
    popped_ok = 1'b0; popped_byte = 8'hxx;
    send_frame(8'h77, 1'b1, lat - 1);
    idle(BIT_CLKS / 2);
    checks++; if (popped_ok !== 1'b1 || popped_byte !== head) begin failures++; $display("FAIL fullpop_popped: got valid=%b data=%h expected valid=1 data=%h", popped_ok, popped_byte, head); end
    checks++; if (ov_pulses - ov0 !== 0) begin failures++; $display("FAIL fullpop_overrun: got %0d pulses expected 0", ov_pulses - ov0); end
    checks++; if (int'(fifo_count) !== DEPTH) begin failures++; $display("FAIL fullpop_count: got %0d expected %0d", fifo_count, DEPTH); end
    drain_fifo();
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL fullpop_drain_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fullpop_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'h77) begin failures++; $display("FAIL fullpop_last: expected 77 last out"); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    send_good(8'h5A);
    idle(BIT_CLKS / 4);
    fork
      send_frame(8'h81, 1'b1, -1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rstmid_rd_data: got %h expected 00", rd_data); end
        checks++; if (int'(fifo_count) !== 0) begin failures++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rstmid_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL rstmid_state: got %0d expected IDLE", state_dbg); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    exp_q.delete();
    idle(2 * BIT_CLKS);
    checks++; if (int'(fifo_count) !== 0) begin failures++; $display("FAIL rstmid_no_partial: got %0d expected 0", fifo_count); end
    send_good(8'h81);
    idle(BIT_CLKS / 4);
    drain_fifo();
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h81) begin failures++; $display("FAIL rstmid_next_byte: got %0d bytes expected 1 byte 81", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  // Random bytes, back to back, some with a bad stop bit, random consumer.
  task automatic test_back_to_back();
    int fe0, guard;
    logic send_done;
    fe0 = fe_pulses; exp_fe = 0; send_done = 1'b0; guard = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] d;
          d = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) begin
            exp_fe++;
            send_frame(d, 1'b0, -1);
            idle(BIT_CLKS);
          end else begin
            send_good(d);
          end
        end
        idle(BIT_CLKS / 2);
        send_done = 1'b1;
      end
      begin
        while ((!send_done || rd_valid) && guard < 20000) begin
          @(negedge clk);
          rd_ready = 1'($urandom_range(0, 1));
          if (rd_valid && rd_ready) got_q.push_back(rd_data);
          guard++;
        end
        rd_ready = 1'b0;
      end
    join
    checks++; if (guard >= 20000) begin failures++; $display("FAIL b2b_timeout: consumer ran %0d cycles", guard); end
    checks++; if (fe_pulses - fe0 !== exp_fe) begin failures++; $display("FAIL b2b_frame_err: got %0d expected %0d", fe_pulses - fe0, exp_fe); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (int'(fifo_count) !== 0) begin failures++; $display("FAIL b2b_count: got %0d expected 0", fifo_count); end
    got_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; failures = 0;
    fe_run = 0; fe_pulses = 0; fe_max = 0;
    ov_run = 0; ov_pulses = 0; ov_max = 0;
    rv_prev = 1'b0; rv_rise_cyc = 0; last_start_cyc = 0; lat = 0;
    exp_ovr = 0; exp_fe = 0;
    rst_n = 1'b0; rxd = 1'b1; rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer entries; power of two, 2 or more.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port rxd, input, 1, meaning asynchronous serial line, idle high.
REQ-007 SHALL have port rd_data, output, 8, meaning head-of-FIFO byte.
REQ-008 SHALL have port rd_valid, output, 1, meaning rd_data holds a valid byte.
REQ-009 SHALL have port rd_ready, input, 1, meaning consumer accepts the byte.
REQ-010 SHALL have port frame_err, output, 1, meaning one-cycle pulse when a bad stop bit is sampled.
REQ-011 SHALL have port overrun, output, 1, meaning one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1), meaning the number of bytes held.

Function
REQ-013 SHALL synchronise rxd through a 2-flop synchroniser; both flops reset to 1.
REQ-014 SHALL derive a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks (integer truncation); the tick counter free-runs only outside IDLE and restarts at start-edge detection.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP (plus PARITY per REQ-028).
REQ-016 SHALL move from IDLE to START on a synchronised 1->0 edge.
REQ-017 SHALL, in START at tick 8, return to IDLE if the line is high (glitch rejection), otherwise enter DATA.
REQ-018 SHALL sample 8 data bits LSB first, each at tick 8 of its bit period (every 16 ticks after the start-bit midpoint).
REQ-019 SHALL sample the stop bit at mid-bit; if high, push the byte into the FIFO; if low, discard the byte, pulse frame_err for 1 clk, and wait in IDLE until the line is high before accepting a new edge.
REQ-020 SHALL return to IDLE from STOP at the stop-bit midpoint, allowing back-to-back frames.
REQ-021 SHALL use a first-word-fall-through FIFO: rd_valid = (count != 0); rd_data is valid in the same cycle; a pop occurs when rd_valid && rd_ready.
REQ-022 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise it drops the byte and pulses overrun for 1 clk, leaving the contents unchanged.
REQ-023 SHALL leave fifo_count unchanged on a simultaneous push and pop; the latency from stop-bit midpoint to rd_valid is 1 clk when the FIFO is empty.
REQ-024 SHALL let the read and write pointers wrap modulo FIFO_DEPTH, with count distinguishing full from empty.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force: state IDLE, pointers and count 0, rd_valid 0, rd_data 0, frame_err 0, overrun 0, tick and bit counters 0.
REQ-026 SHALL, when reset is asserted mid-frame, abandon the partial byte; after release, receive only a frame whose start edge follows the release.

Configuration
REQ-027 SHALL use the macro UART_RX_PARITY_EN; when undefined, the frame is 8N1 and there is no PARITY state.
REQ-028 SHALL, when UART_RX_PARITY_EN is defined, expect an even-parity bit between DATA and STOP and add output parity_err (1 bit); on a mismatch it pulses parity_err for 1 clk and discards the byte, and the stop bit is still checked.

Structure
REQ-029 SHALL place the state enum and the oversample constant (16) in the shared package uart_pkg.
REQ-030 SHALL implement the FIFO as sub-module uart_rx_fifo (parameter DEPTH, width 8), with the FSM and bit timing in uart_rx.

Verification
REQ-031 SHALL cover a single frame: CLK_HZ=50e6, BAUD=115200 (DIV=27, bit=432 clk), send 0xA5 8N1 -> rd_valid rises, rd_data=0xA5, fifo_count=1.
REQ-032 SHALL cover a glitch: a 100-clk low pulse on rxd -> no push, state returns to IDLE, frame_err stays 0.
REQ-033 SHALL cover a framing error: send 0x3C with stop bit low -> frame_err is a 1-clk pulse, fifo_count stays 0; a following 0x55 is received correctly.
REQ-034 SHALL cover overflow: send 17 back-to-back bytes 0x00..0x10 with rd_ready=0 -> fifo_count=16, one overrun pulse, and reads return 0x00..0x0F in order.
REQ-035 SHALL cover full push plus pop: FIFO full and rd_ready=1 at the stop midpoint of byte 0x77 -> no overrun, count stays 16, 0x77 is last out.
REQ-036 SHALL cover reset mid-frame: assert rst_n low during data bit 4 -> all outputs 0; next full frame 0x81 is received correctly.
